// File: rtl/relin_pkg.sv
// Shared types for the relinearization tile sequencer: default sizing,
// the tile container and the sequencer FSM state encoding.
package relin_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int DEGREE_N_DEF   = 16;
  localparam int TILE_WIDTH_DEF = 4;
  localparam int NUM_PASSES_DEF = 2;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef logic [TILE_WIDTH_DEF-1:0][DATA_WIDTH_DEF-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_UNIT = 2'd2,
    FINISH    = 2'd3
  } state_e;

endpackage

// File: rtl/relin_tile_skid_fifo.sv
// Two-entry registered FIFO that decouples buffer read latency from
// relin_unit backpressure; exposes its occupancy for read throttling.
module relin_tile_skid_fifo #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en_i) wr_ptr_q <= ~wr_ptr_q;
      if (rd_en_i) rd_ptr_q <= ~rd_ptr_q;
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Storage is not reset, so the head is masked while empty to keep the output clean.
  assign rd_data_o = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(wr_en_i && !rd_en_i && (count_q == 2'd2)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(rd_en_i && (count_q == 2'd0)));

endmodule

// File: rtl/relin_tile_sequencer.sv
// Fetches a c2 polynomial tile by tile from the coefficient buffer and
// streams it to relin_unit once per relin-key component.
module relin_tile_sequencer
  import relin_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEGREE_N   = DEGREE_N_DEF,
  parameter int TILE_WIDTH = TILE_WIDTH_DEF,
  parameter int NUM_PASSES = NUM_PASSES_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             rd_en_o,
  output logic [ADDR_WIDTH-1:0]            rd_addr_o,
  input  logic [TILE_WIDTH*DATA_WIDTH-1:0] rd_data_i,
  output logic                             valid_o,
  output logic [TILE_WIDTH*DATA_WIDTH-1:0] coeff_o,
  output logic                             key_select_o,
  input  logic                             ready_i,
  input  logic                             unit_done_i
);

  localparam int NUM_TILES = DEGREE_N / TILE_WIDTH;
  localparam int TILE_BITS = TILE_WIDTH * DATA_WIDTH;
  localparam int FW        = $clog2(NUM_TILES + 1);
  localparam int SW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int PW        = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  localparam logic [FW-1:0] FETCH_END = FW'(NUM_TILES);
  localparam logic [SW-1:0] SEND_LAST = SW'(NUM_TILES - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [FW-1:0]           fetch_q, fetch_d;
  logic [SW-1:0]           send_q, send_d;
  logic [PW-1:0]           pass_q, pass_d;
  logic                    inflight_q;
  logic [1:0]              occ;
  logic                    fire;
  logic                    issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      fetch_q    <= '0;
      send_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      fetch_q    <= fetch_d;
      send_q     <= send_d;
      pass_q     <= pass_d;
      inflight_q <= rd_en_o;
    end
  end

  assign valid_o = (occ != 2'd0);
  assign fire    = valid_o & ready_i;

  // Tiles already buffered plus the one in flight must leave room after this cycle's pop.
  assign issue = (fetch_q < FETCH_END) &&
                 (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, fire}));

  assign rd_addr_o    = base_q + ADDR_WIDTH'(fetch_q);
  assign key_select_o = pass_q[0];
  assign busy_o       = (state_q == STREAM) || (state_q == WAIT_UNIT);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    fetch_d = fetch_q;
    send_d  = send_q;
    pass_d  = pass_q;
    rd_en_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          fetch_d = '0;
          send_d  = '0;
          pass_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        rd_en_o = issue;
        if (issue) fetch_d = fetch_q + FW'(1);
        if (fire) begin
          send_d = send_q + SW'(1);
          if (send_q == SEND_LAST) begin
            send_d  = '0;
            state_d = WAIT_UNIT;
          end
        end
      end
      WAIT_UNIT: begin
        if (unit_done_i) begin
          if (pass_q == PASS_LAST) begin
            state_d = FINISH;
          end else begin
            pass_d  = pass_q + PW'(1);
            fetch_d = '0;
            send_d  = '0;
            state_d = STREAM;
          end
        end
      end
      FINISH: begin
        done_o  = 1'b1;
        pass_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  relin_tile_skid_fifo #(
    .WIDTH(TILE_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (inflight_q),
    .wr_data_i(rd_data_i),
    .rd_en_i  (fire),
    .rd_data_o(coeff_o),
    .count_o  (occ)
  );

endmodule
